// File: rtl/cdb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cdb_pkg
// Purpose : Shared definitions for the common-data-bus writeback path.
//           Default widths, the broadcast bundle seen by consumers, and the
//           round-robin pointer advance helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package cdb_pkg;

  localparam int CDB_NUM_REQ = 4;
  localparam int CDB_DATA_W  = 16;
  localparam int CDB_TAG_W   = 3;
  localparam int CDB_IDX_W   = $clog2(CDB_NUM_REQ);

  // Broadcast as seen by the register file / reservation stations.
  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
    logic [CDB_IDX_W-1:0]  src;
  } cdb_bus_t;

  // Next round-robin start position after granting idx; wraps at n, so
  // non-power-of-two requester counts never reach an unused index.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_reg.sv
`default_nettype none
// ============================================================================
// Module  : cdb_reg
// Purpose : Generic load-enable register with asynchronous active-low clear.
// Ports   : clk   in  1      rising-edge clock
//           rst_n in  1      asynchronous active-low reset (clears q)
//           en    in  1      load enable
//           d     in  WIDTH  data in
//           q     out WIDTH  registered data
// Revision: 1.0 - initial release
// ============================================================================
module cdb_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Purpose : Combinational round-robin arbiter. Scans requests starting at
//           ptr and wrapping modulo N; the first active request wins.
// Ports   : req    in  N      request vector
//           ptr    in  IDX_W  highest-priority index this cycle
//           enable in  1      when low, no grant is issued
//           gnt    out N      one-hot grant (all-zero when nothing granted)
//           idx    out IDX_W  encoded index of the granted request
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             enable,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  logic             w_found;
  logic [IDX_W-1:0] w_pos;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    w_found = 1'b0;
    w_pos   = '0;
    if (enable) begin
      for (int k = 0; k < N; k++) begin
        w_pos = IDX_W'((int'(ptr) + k) % N);
        if (!w_found && req[w_pos]) begin
          gnt[w_pos] = 1'b1;
          idx        = w_pos;
          w_found    = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cdb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : cdb_wb_arbiter
// Purpose : Shares the common-data-bus writeback path between NUM_REQ
//           functional units. Round-robin grant each cycle, then a one-cycle
//           registered broadcast of the winner's tag, data and index.
// Ports   : clk       in  1               rising-edge clock
//           rst_n     in  1               asynchronous active-low reset
//           req_valid in  NUM_REQ         per-requester writeback request
//           req_tag   in  NUM_REQ*TAG_W   packed tags, [i*TAG_W +: TAG_W]
//           req_data  in  NUM_REQ*DATA_W  packed data, [i*DATA_W +: DATA_W]
//           req_ready out NUM_REQ         one-hot grant
//           hold      in  1               downstream stall, blocks grants
//           flush     in  1               pipeline squash, blocks grants
//           cdb_valid out 1               broadcast valid (one-cycle pulse)
//           cdb_tag   out TAG_W           broadcast tag
//           cdb_data  out DATA_W          broadcast data
//           cdb_src   out IDX_W           index of the broadcasting requester
// Revision: 1.0 - initial release
// ============================================================================
module cdb_wb_arbiter
  import cdb_pkg::*;
#(
  parameter  int NUM_REQ = CDB_NUM_REQ,
  parameter  int DATA_W  = CDB_DATA_W,
  parameter  int TAG_W   = CDB_TAG_W,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      hold,
  input  logic                      flush,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [IDX_W-1:0]          cdb_src
);

  localparam int C_PAYLOAD_W = TAG_W + DATA_W + IDX_W;

  logic [IDX_W-1:0]       r_rr_ptr;
  logic [NUM_REQ-1:0]     w_gnt;
  logic [IDX_W-1:0]       w_idx;
  logic                   w_any;
  logic                   w_enable;
  logic [TAG_W-1:0]       w_sel_tag;
  logic [DATA_W-1:0]      w_sel_data;
  logic [C_PAYLOAD_W-1:0] w_payload_q;

  // rst_n gates the grant so no requester sees ready during reset.
  assign w_enable = rst_n & ~hold & ~flush;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req    (req_valid),
    .ptr    (r_rr_ptr),
    .enable (w_enable),
    .gnt    (w_gnt),
    .idx    (w_idx)
  );

  assign w_any     = |w_gnt;
  assign req_ready = w_gnt;

  // One-hot mux of the granted requester's payload.
  always_comb begin
    w_sel_tag  = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_tag  = req_tag[i*TAG_W +: TAG_W];
        w_sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_any) begin
      r_rr_ptr <= IDX_W'(rr_next(int'(w_idx), NUM_REQ));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid <= 1'b0;
    end else begin
      cdb_valid <= w_any;
    end
  end

  // Payload only loads on a grant; between broadcasts it keeps the last value.
  cdb_reg #(
    .WIDTH (C_PAYLOAD_W)
  ) u_payload_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_any),
    .d     ({w_sel_tag, w_sel_data, w_idx}),
    .q     (w_payload_q)
  );

  assign {cdb_tag, cdb_data, cdb_src} = w_payload_q;

endmodule
`default_nettype wire

// File: tb/tb_cdb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_cdb_wb_arbiter
// Purpose : Self-checking bench for cdb_wb_arbiter (NUM_REQ=4 and NUM_REQ=3).
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_cdb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [11:0] req_tag;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        hold, flush;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic [1:0]  cdb_src;

  logic [2:0]  req_valid3;
  logic [8:0]  req_tag3;
  logic [47:0] req_data3;
  logic [2:0]  req_ready3;
  logic        hold3, flush3;
  logic        cdb_valid3;
  logic [2:0]  cdb_tag3;
  logic [15:0] cdb_data3;
  logic [1:0]  cdb_src3;

  always #5 clk = ~clk;

  cdb_wb_arbiter u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_tag(req_tag),
    .req_data(req_data), .req_ready(req_ready), .hold(hold), .flush(flush),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src)
  );

  cdb_wb_arbiter #(.NUM_REQ(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_tag(req_tag3),
    .req_data(req_data3), .req_ready(req_ready3), .hold(hold3), .flush(flush3),
    .cdb_valid(cdb_valid3), .cdb_tag(cdb_tag3), .cdb_data(cdb_data3), .cdb_src(cdb_src3)
  );

  typedef struct {
    logic [3:0] valid;
    logic       hold;
    logic       flush;
    logic [3:0] exp_ready;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [2:0]  tag;
    logic [15:0] data;
    logic [1:0]  src;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t sbq[$];
  logic [2:0]  tags[4];
  logic [15:0] datas[4];
  vec_t vecs[25];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: compare last edge's broadcast, drive new inputs, check grant,
  // and queue the broadcast the next edge must produce.
  task automatic step(input logic [3:0] v, input logic h, input logic f, input logic [3:0] exp_rdy);
    exp_t e;
    @(negedge clk);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("cdb_valid", {63'd0, cdb_valid}, {63'd0, e.valid});
      if (e.valid) begin
        check("cdb_tag", {61'd0, cdb_tag}, {61'd0, e.tag});
        check("cdb_data", {48'd0, cdb_data}, {48'd0, e.data});
        check("cdb_src", {62'd0, cdb_src}, {62'd0, e.src});
      end
    end
    req_valid = v;
    hold      = h;
    flush     = f;
    for (int i = 0; i < 4; i++) begin
      req_tag[i*3 +: 3]    = tags[i];
      req_data[i*16 +: 16] = datas[i];
    end
    #1;
    check("req_ready", {60'd0, req_ready}, {60'd0, exp_rdy});
    e.valid = |exp_rdy;
    e.src   = 2'd0;
    for (int i = 0; i < 4; i++) if (exp_rdy[i]) e.src = 2'(i);
    e.tag  = tags[e.src];
    e.data = datas[e.src];
    sbq.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{4'b1111, 1'b0, 1'b0, 4'b0001};
    vecs[1]  = '{4'b1111, 1'b0, 1'b0, 4'b0010};
    vecs[2]  = '{4'b1111, 1'b0, 1'b0, 4'b0100};
    vecs[3]  = '{4'b1111, 1'b0, 1'b0, 4'b1000};
    vecs[4]  = '{4'b1111, 1'b0, 1'b0, 4'b0001};
    vecs[5]  = '{4'b1111, 1'b0, 1'b0, 4'b0010};
    vecs[6]  = '{4'b1111, 1'b0, 1'b0, 4'b0100};
    vecs[7]  = '{4'b1111, 1'b0, 1'b0, 4'b1000};
    vecs[8]  = '{4'b0100, 1'b0, 1'b0, 4'b0100};
    vecs[9]  = '{4'b0000, 1'b0, 1'b0, 4'b0000};
    vecs[10] = '{4'b0011, 1'b0, 1'b0, 4'b0001};
    vecs[11] = '{4'b0011, 1'b0, 1'b0, 4'b0010};
    vecs[12] = '{4'b0010, 1'b1, 1'b0, 4'b0000};
    vecs[13] = '{4'b0010, 1'b1, 1'b0, 4'b0000};
    vecs[14] = '{4'b0010, 1'b1, 1'b0, 4'b0000};
    vecs[15] = '{4'b0010, 1'b0, 1'b0, 4'b0010};
    vecs[16] = '{4'b0001, 1'b0, 1'b1, 4'b0000};
    vecs[17] = '{4'b0001, 1'b0, 1'b0, 4'b0001};
    vecs[18] = '{4'b1111, 1'b1, 1'b1, 4'b0000};
    vecs[19] = '{4'b1010, 1'b0, 1'b0, 4'b0010};
    vecs[20] = '{4'b1010, 1'b0, 1'b0, 4'b1000};
    vecs[21] = '{4'b1001, 1'b0, 1'b1, 4'b0000};
    vecs[22] = '{4'b1001, 1'b0, 1'b0, 4'b0001};
    vecs[23] = '{4'b1001, 1'b0, 1'b0, 4'b1000};
    vecs[24] = '{4'b0000, 1'b0, 1'b0, 4'b0000};

    rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
    req_valid = 4'b1111; req_tag = '0; req_data = '0;
    req_valid3 = '0; req_tag3 = '0; req_data3 = '0; hold3 = 1'b0; flush3 = 1'b0;
    for (int i = 0; i < 4; i++) begin tags[i] = '0; datas[i] = '0; end

    // Reset state, with requests present to confirm ready is forced low.
    repeat (2) @(negedge clk);
    check("rst_cdb_valid", {63'd0, cdb_valid}, 64'd0);
    check("rst_cdb_tag", {61'd0, cdb_tag}, 64'd0);
    check("rst_cdb_data", {48'd0, cdb_data}, 64'd0);
    check("rst_cdb_src", {62'd0, cdb_src}, 64'd0);
    check("rst_req_ready", {60'd0, req_ready}, 64'd0);
    req_valid = 4'b0000;
    rst_n = 1'b1;

    // Table-driven sequence from a fresh pointer.
    for (int s = 0; s < 25; s++) begin
      for (int i = 0; i < 4; i++) begin
        tags[i]  = 3'((i * 3 + s) % 8);
        datas[i] = 16'hA500 ^ 16'(s * 16 + i);
      end
      step(vecs[s].valid, vecs[s].hold, vecs[s].flush, vecs[s].exp_ready);
    end
    step(4'b0000, 1'b0, 1'b0, 4'b0000);

    // Reset asserted while a broadcast is live.
    step(4'b1111, 1'b0, 1'b0, 4'b0001);
    @(posedge clk);
    #1;
    check("pre_rst_cdb_valid", {63'd0, cdb_valid}, 64'd1);
    check("pre_rst_rr_ptr", {62'd0, u_dut.r_rr_ptr}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_cdb_valid", {63'd0, cdb_valid}, 64'd0);
    check("async_rst_cdb_tag", {61'd0, cdb_tag}, 64'd0);
    check("async_rst_cdb_data", {48'd0, cdb_data}, 64'd0);
    check("async_rst_cdb_src", {62'd0, cdb_src}, 64'd0);
    check("async_rst_rr_ptr", {62'd0, u_dut.r_rr_ptr}, 64'd0);
    check("async_rst_ready", {60'd0, req_ready}, 64'd0);
    sbq.delete();
    @(negedge clk);
    req_valid = 4'b0000;
    rst_n = 1'b1;
    step(4'b1000, 1'b0, 1'b0, 4'b1000);
    step(4'b0000, 1'b0, 1'b0, 4'b0000);

    // Single request with known tag/data on requester 2.
    tags[2] = 3'd5;
    datas[2] = 16'hBEEF;
    step(4'b0100, 1'b0, 1'b0, 4'b0100);
    step(4'b0000, 1'b0, 1'b0, 4'b0000);
    step(4'b0000, 1'b0, 1'b0, 4'b0000);
    step(4'b0000, 1'b0, 1'b0, 4'b0000);

    // Three-requester build: wrap 2 -> 0.
    for (int i = 0; i < 3; i++) begin
      req_tag3[i*3 +: 3]    = 3'(i + 1);
      req_data3[i*16 +: 16] = 16'h3000 + 16'(i);
    end
    for (int s = 0; s < 7; s++) begin
      logic [2:0] exp3;
      @(negedge clk);
      if (s > 0) begin
        check("n3_cdb_valid", {63'd0, cdb_valid3}, 64'd1);
        check("n3_cdb_src", {62'd0, cdb_src3}, 64'((s - 1) % 3));
        check("n3_cdb_tag", {61'd0, cdb_tag3}, 64'((s - 1) % 3 + 1));
        check("n3_cdb_data", {48'd0, cdb_data3}, 64'h3000 + 64'((s - 1) % 3));
      end
      req_valid3 = (s < 6) ? 3'b111 : 3'b000;
      exp3 = (s < 6) ? 3'(1 << (s % 3)) : 3'b000;
      #1;
      check("n3_req_ready", {61'd0, req_ready3}, {61'd0, exp3});
      check("n3_ptr_range", {63'd0, (u_dut3.r_rr_ptr < 2'd3)}, 64'd1);
    end
    @(negedge clk);
    check("n3_idle_valid", {63'd0, cdb_valid3}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
